// File: rtl/swi_pkg.sv
// Shared types and default parameters for the switch input conditioner.
//   ev_state_t          : change-event channel FSM states
//   NBITS_TOP           : default switch vector width
//   SYNC_STAGES_DEF     : default synchronizer depth per bit
//   DEBOUNCE_CYCLES_DEF : default consecutive-mismatch count before a change
package swi_pkg;

    typedef enum logic {
        EV_IDLE    = 1'b0,
        EV_PENDING = 1'b1
    } ev_state_t;

    localparam int NBITS_TOP           = 8;
    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 4;

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: synchronizer chain, mismatch counter, clean flop and
// registered rise/fall pulses.
//   clk_2     : clock, all state on rising edge
//   reset     : asynchronous, active-high
//   raw       : raw pin, asynchronous to clk_2
//   clean     : debounced level
//   clean_nxt : value clean takes on the coming edge (lets the parent see a
//               change on the same edge it lands; derived from flops only)
//   rise/fall : one-cycle pulses, registered on the edge clean changes
module debounce_bit
    import swi_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk_2,
    input  logic reset,
    input  logic raw,
    output logic clean,
    output logic clean_nxt,
    output logic rise,
    output logic fall
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;

    assign s = sync[SYNC_STAGES-1];

    // The counter only runs while the synchronized input disagrees with the
    // clean level; any agreement discards the partial count, so a glitch
    // shorter than DEBOUNCE_CYCLES never reaches the output.
    always_comb begin
        cnt_nxt   = '0;
        clean_nxt = clean;
        if (s != clean) begin
            if (cnt == CNT_LAST) begin
                clean_nxt = s;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            sync  <= '0;
            cnt   <= '0;
            clean <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], raw};
            cnt   <= cnt_nxt;
            clean <= clean_nxt;
            rise  <= clean_nxt & ~clean;
            fall  <= ~clean_nxt & clean;
        end
    end

endmodule

// File: rtl/swi_debounce.sv
// Board switch conditioner: per-bit synchronize + debounce, edge pulses and a
// valid/ready change-event channel with a sticky overrun flag.
//   clk_2         : clock, all state on rising edge
//   reset         : asynchronous, active-high
//   swi_raw       : raw switch pins (asynchronous)
//   swi_clean     : debounced switch vector
//   rise/fall     : per-bit one-cycle edge pulses
//   event_valid   : change event pending
//   event_data    : swi_clean snapshot of the pending event
//   event_ready   : consumer accepts the event
//   event_overrun : sticky, a pending event was overwritten before acceptance
//   overrun_clr   : synchronous clear of event_overrun (a coincident set wins)
//
// Event FSM states:
//   state      | meaning
//   EV_IDLE    | no event outstanding, event_valid low
//   EV_PENDING | event_valid high, event_data held until accepted
module swi_debounce
    import swi_pkg::*;
#(
    parameter int NBITS           = NBITS_TOP,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic [NBITS-1:0] swi_raw,
    output logic [NBITS-1:0] swi_clean,
    output logic [NBITS-1:0] rise,
    output logic [NBITS-1:0] fall,
    output logic             event_valid,
    output logic [NBITS-1:0] event_data,
    input  logic             event_ready,
    output logic             event_overrun,
    input  logic             overrun_clr
);

    logic [NBITS-1:0] clean_nxt;
    logic             change;

    ev_state_t        state;
    ev_state_t        state_nxt;
    logic [NBITS-1:0] data_nxt;
    logic             overrun_nxt;

    for (genvar i = 0; i < NBITS; i++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk_2     (clk_2),
            .reset     (reset),
            .raw       (swi_raw[i]),
            .clean     (swi_clean[i]),
            .clean_nxt (clean_nxt[i]),
            .rise      (rise[i]),
            .fall      (fall[i])
        );
    end

    // Looking at clean_nxt rather than the clean flops lets the event land on
    // the same edge as swi_clean and the rise/fall pulses.
    assign change = (clean_nxt != swi_clean);

    assign event_valid = (state == EV_PENDING);

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state         <= EV_IDLE;
            event_data    <= '0;
            event_overrun <= 1'b0;
        end else begin
            state         <= state_nxt;
            event_data    <= data_nxt;
            event_overrun <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        data_nxt    = event_data;
        overrun_nxt = event_overrun & ~overrun_clr;
        case (state)
            EV_IDLE: begin
                if (change) begin
                    data_nxt  = clean_nxt;
                    state_nxt = EV_PENDING;
                end
            end
            EV_PENDING: begin
                if (change) begin
                    // Accept-and-reload when ready coincides; otherwise the
                    // unread event is overwritten and flagged.
                    data_nxt = clean_nxt;
                    if (!event_ready) begin
                        overrun_nxt = 1'b1;
                    end
                end else if (event_ready) begin
                    state_nxt = EV_IDLE;
                end
            end
            default: begin
                state_nxt = EV_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_swi_debounce.sv
module tb_swi_debounce;

    logic       clk_2 = 1'b0;
    logic       reset;
    logic [7:0] swi_raw;
    logic [7:0] swi_clean;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       event_valid;
    logic [7:0] event_data;
    logic       event_ready;
    logic       event_overrun;
    logic       overrun_clr;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    swi_debounce dut (
        .clk_2         (clk_2),
        .reset         (reset),
        .swi_raw       (swi_raw),
        .swi_clean     (swi_clean),
        .rise          (rise),
        .fall          (fall),
        .event_valid   (event_valid),
        .event_data    (event_data),
        .event_ready   (event_ready),
        .event_overrun (event_overrun),
        .overrun_clr   (overrun_clr)
    );

    always #5 clk_2 = ~clk_2;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, required finish before timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pops the oldest expected event and compares it with the DUT channel.
    task automatic expect_event(input string tag);
        logic [7:0] e;
        check({tag, "_valid"}, {31'd0, event_valid}, 32'd1);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = 8'hxx;
        check({tag, "_data"}, {24'd0, event_data}, {24'd0, e});
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {7'd0, swi_clean, rise, fall, event_valid}, 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        swi_raw     = 8'h00;
        event_ready = 1'b0;
        overrun_clr = 1'b0;

        // Reset and idle
        repeat (3) tick();
        check("rst_hold", {7'd0, swi_clean, rise, fall, event_valid}, 32'd0);
        check("rst_hold_ev", {23'd0, event_data, event_overrun}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_all_zero("idle");
        end
        check("idle_ovr", {31'd0, event_overrun}, 32'd0);

        // Single bit rise then fall, ready held high
        event_ready = 1'b1;
        swi_raw = 8'h01;
        exp_q.push_back(8'h01);
        repeat (5) tick();
        check("rise_early", {24'd0, swi_clean}, 32'h00);
        tick();
        check("rise_clean", {24'd0, swi_clean}, 32'h01);
        check("rise_pulse", {24'd0, rise}, 32'h01);
        check("rise_nofall", {24'd0, fall}, 32'h00);
        expect_event("rise_ev");
        tick();
        check("rise_width", {24'd0, rise}, 32'h00);
        check("rise_ev_drop", {31'd0, event_valid}, 32'd0);
        check("rise_hold", {24'd0, swi_clean}, 32'h01);

        swi_raw = 8'h00;
        exp_q.push_back(8'h00);
        repeat (5) tick();
        check("fall_early", {24'd0, swi_clean}, 32'h01);
        tick();
        check("fall_clean", {24'd0, swi_clean}, 32'h00);
        check("fall_pulse", {24'd0, fall}, 32'h01);
        check("fall_norise", {24'd0, rise}, 32'h00);
        expect_event("fall_ev");
        tick();
        check("fall_width", {24'd0, fall}, 32'h00);
        check("fall_ev_drop", {31'd0, event_valid}, 32'd0);

        // Glitch of 3 cycles on bit 3 is rejected
        swi_raw = 8'h08;
        repeat (3) tick();
        swi_raw = 8'h00;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_all_zero("glitch");
        end

        // Coalescing with ready low, then accept, then overrun clear
        event_ready = 1'b0;
        swi_raw = 8'h01;
        exp_q.push_back(8'h01);
        repeat (6) tick();
        expect_event("coal_first");
        check("coal_ovr0", {31'd0, event_overrun}, 32'd0);
        swi_raw = 8'h03;
        exp_q.push_back(8'h03);
        repeat (5) tick();
        check("coal_stable", {24'd0, event_data}, 32'h01);
        check("coal_ovr_pre", {31'd0, event_overrun}, 32'd0);
        tick();
        expect_event("coal_second");
        check("coal_ovr1", {31'd0, event_overrun}, 32'd1);
        event_ready = 1'b1;
        tick();
        check("coal_accept", {31'd0, event_valid}, 32'd0);
        repeat (3) tick();
        check("ovr_sticky", {31'd0, event_overrun}, 32'd1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("ovr_clr", {31'd0, event_overrun}, 32'd0);

        // Ready on the same edge a new change lands
        event_ready = 1'b0;
        swi_raw = 8'h07;
        exp_q.push_back(8'h07);
        repeat (6) tick();
        expect_event("same_first");
        repeat (2) tick();
        swi_raw = 8'h0F;
        exp_q.push_back(8'h0F);
        repeat (5) tick();
        check("same_pre", {24'd0, event_data}, 32'h07);
        event_ready = 1'b1;
        tick();
        expect_event("same_reload");
        check("same_noovr", {31'd0, event_overrun}, 32'd0);
        check("same_rise", {24'd0, rise}, 32'h08);
        tick();
        check("same_drop", {31'd0, event_valid}, 32'd0);
        check("same_clean", {24'd0, swi_clean}, 32'h0F);

        // Reset while bit 4 is mid-count, raw kept high across reset
        swi_raw = 8'h1F;
        repeat (4) tick();
        reset = 1'b1;
        #1;
        check("mid_rst_out", {7'd0, swi_clean, rise, fall, event_valid}, 32'd0);
        check("mid_rst_ev", {23'd0, event_data, event_overrun}, 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        exp_q.push_back(8'h1F);
        repeat (5) tick();
        check("post_rst_early", {24'd0, swi_clean}, 32'h00);
        tick();
        check("post_rst_clean", {24'd0, swi_clean}, 32'h1F);
        check("post_rst_rise", {24'd0, rise}, 32'h1F);
        expect_event("post_rst_ev");
        tick();
        check("post_rst_drop", {31'd0, event_valid}, 32'd0);

        check("sb_drain", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
